cache_tag_stage: RTL
====================

Name: cache_tag_stage

Overview:
- Two-stage tag lookup pipeline that sits directly upstream of the cache LRU block and drives its access, update and fill ports.
- Stage 1 accepts a request, reads the per-set tag/valid arrays and issues the LRU access.
- Stage 2 compares tags, reports hit/miss and hit way, and sends an LRU update on hit.
- Also runs the two-cycle fill sequence: request a victim way from the LRU, then write the new tag and set its valid bit.

Parameters:
- NUM_WAYS, 4, associativity (fixed at 4 to match the LRU tree).
- NUM_SETS, 16, number of sets.
- TAG_WIDTH, 20, tag bits per line.
- NUM_WAYS_LOG, $clog2(NUM_WAYS), way index width.
- NUM_SETS_LOG, $clog2(NUM_SETS), set index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_set  in  NUM_SETS_LOG  lookup set.
- req_tag  in  TAG_WIDTH  lookup tag.
- resp_valid  out  1  stage-2 result valid.
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  NUM_WAYS_LOG  matching way (0 on miss).
- resp_set  out  NUM_SETS_LOG  set of the stage-2 request.
- resp_tag  out  TAG_WIDTH  tag of the stage-2 request.
- fill_valid  in  1  fill request from the miss handler.
- fill_ready  out  1  fill accepted.
- fill_set  in  NUM_SETS_LOG  fill set.
- fill_tag  in  TAG_WIDTH  fill tag.
- fill_done  out  1  one-cycle pulse when the fill tag is written.
- fill_done_way  out  NUM_WAYS_LOG  way written.
- lru_access_en  out  1  to LRU access_en.
- lru_access_set  out  NUM_SETS_LOG  to LRU access_set.
- lru_update_en  out  1  to LRU update_en.
- lru_update_way  out  NUM_WAYS_LOG  to LRU update_way_idx.
- lru_fill_en  out  1  to LRU fill_en.
- lru_fill_set  out  NUM_SETS_LOG  to LRU fill_set.
- lru_fill_way  in  NUM_WAYS_LOG  from LRU fill_way_idx; valid the cycle after lru_fill_en.

Behaviour:
- Reset, asynchronous:
  - All valid bits cleared; fill FSM goes to IDLE.
  - resp_valid, resp_hit, resp_way, fill_done, fill_done_way and all lru_* enables are 0.
  - Tag storage is not reset.
- Stage 1, cycle N:
  - On req_valid & req_ready: lru_access_en=1, lru_access_set=req_set.
  - Tags and valid bits of req_set are registered into stage 2.
- Stage 2, cycle N+1:
  - resp_valid=1, with resp_set and resp_tag echoed.
  - resp_hit = OR over ways of (valid & tag==req_tag).
  - resp_way = index of the matching way. Multiple matches are illegal; the lowest index wins.
  - lru_update_en = resp_valid & resp_hit, with lru_update_way = resp_way (combinational from stage 2).
- Throughput: one request per cycle, no backpressure on responses.
- Fill FSM states and transitions:
  - IDLE: fill_ready=1. On fill_valid, latch set/tag, drive lru_fill_en=1 and lru_fill_set=fill_set, go to WRITE.
  - WRITE: fill_ready=0. Sample lru_fill_way, write tag[set][way]=tag and valid=1, pulse fill_done with fill_done_way=lru_fill_way, return to IDLE.
- Arbitration:
  - req_ready = (state==IDLE) & ~fill_valid. Fill has priority, and no request is accepted in either fill cycle, so the LRU never sees access_en and fill_en together.
  - A request already in stage 2 when a fill starts completes with the pre-fill array contents (a stale miss is allowed).
  - Its lru_update_en may coincide with lru_fill_en; this is legal.
- A fill to a set/way that is already valid overwrites it; replacement is decided only by the LRU.
- Back-to-back fills: a new fill is accepted in the IDLE cycle immediately after WRITE, giving one fill per 2 cycles.
- Reset asserted mid-fill aborts the fill with no tag write and no fill_done.

Optional Feature:
- Macro CACHE_TAG_FLUSH_EN.
- When defined, adds input flush_req and outputs flush_busy and flush_done. The state machine gains a FLUSH state, entered from IDLE on flush_req; flush_req has priority over fill_valid.
- In FLUSH, an NUM_SETS_LOG-bit counter clears one set's valid bits per cycle, from 0 up to NUM_SETS-1.
- flush_busy=1 for the whole flush, and req_ready and fill_ready are 0.
- flush_done pulses one cycle after the last set is cleared; the FSM then returns to IDLE.
- Undefined: no ports or state are added, and behaviour is exactly as above.

Test Plan:
- Reset, then lookup set 3 tag 0x12345 -> resp_valid=1, resp_hit=0 one cycle later; lru_access_en=1 with set 3 in the issue cycle.
- Fill set 3 tag 0x12345 with lru_fill_way=2 -> lru_fill_en pulse, then fill_done=1 with way 2 the next cycle. A lookup of the same set/tag then gives hit=1, way=2, lru_update_en=1, lru_update_way=2.
- fill_valid and req_valid in the same cycle -> req_ready=0 for 2 cycles; the fill completes and the request is accepted on cycle 3.
- Four back-to-back lookups to sets 0..3 with no fills -> four consecutive resp_valid cycles, each with the matching resp_set.
- Assert rst during fill WRITE -> fill_done stays 0, and a later lookup of the filled tag misses.
- With CACHE_TAG_FLUSH_EN, fill 2 sets, then flush_req -> flush_busy for 16 cycles, flush_done pulse, and both tags then miss.

Source files
------------

// File: rtl/cache_tag_stage.sv
// Two-stage tag lookup pipeline with a two-cycle fill sequencer feeding the cache LRU block.
// Optional feature: define CACHE_TAG_FLUSH_EN to add a whole-cache valid-bit flush sequence.
module cache_tag_stage #(
    parameter int NUM_WAYS     = 4,
    parameter int NUM_SETS     = 16,
    parameter int TAG_WIDTH    = 20,
    parameter int NUM_WAYS_LOG = $clog2(NUM_WAYS),
    parameter int NUM_SETS_LOG = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NUM_SETS_LOG-1:0] req_set,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [NUM_WAYS_LOG-1:0] resp_way,
    output logic [NUM_SETS_LOG-1:0] resp_set,
    output logic [TAG_WIDTH-1:0]    resp_tag,
    input  logic                    fill_valid,
    output logic                    fill_ready,
    input  logic [NUM_SETS_LOG-1:0] fill_set,
    input  logic [TAG_WIDTH-1:0]    fill_tag,
    output logic                    fill_done,
    output logic [NUM_WAYS_LOG-1:0] fill_done_way,
`ifdef CACHE_TAG_FLUSH_EN
    input  logic                    flush_req,
    output logic                    flush_busy,
    output logic                    flush_done,
`endif
    output logic                    lru_access_en,
    output logic [NUM_SETS_LOG-1:0] lru_access_set,
    output logic                    lru_update_en,
    output logic [NUM_WAYS_LOG-1:0] lru_update_way,
    output logic                    lru_fill_en,
    output logic [NUM_SETS_LOG-1:0] lru_fill_set,
    input  logic [NUM_WAYS_LOG-1:0] lru_fill_way
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept_fill;
    logic                    do_write;
    logic [NUM_SETS_LOG-1:0] fill_set_q;
    logic [TAG_WIDTH-1:0]    fill_tag_q;

    logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
    logic [TAG_WIDTH-1:0]    tag_q   [NUM_SETS][NUM_WAYS];

    logic                    s2_valid_q;
    logic [NUM_SETS_LOG-1:0] s2_set_q;
    logic [TAG_WIDTH-1:0]    s2_tag_q;
    logic [NUM_WAYS-1:0]     s2_vbits_q;
    logic [TAG_WIDTH-1:0]    s2_tags_q [NUM_WAYS];

`ifdef CACHE_TAG_FLUSH_EN
    localparam logic [NUM_SETS_LOG-1:0] LAST_SET = NUM_SETS_LOG'(NUM_SETS - 1);
    logic [NUM_SETS_LOG-1:0] flush_cnt_q;
    logic                    flush_done_q;
`endif

    // Fill (and flush) sequencer; any non-idle state blocks new lookups so the
    // LRU never sees an access and a fill in the same cycle.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        fill_ready  = 1'b0;
        accept_fill = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef CACHE_TAG_FLUSH_EN
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else
`endif
                begin
                    fill_ready = 1'b1;
                    req_ready  = ~fill_valid;
                    if (fill_valid) begin
                        accept_fill = 1'b1;
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
`ifdef CACHE_TAG_FLUSH_EN
            ST_FLUSH: begin
                if (flush_cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_set_q <= '0;
            fill_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_fill) begin
                fill_set_q <= fill_set;
                fill_tag_q <= fill_tag;
            end
        end
    end

    assign do_write       = (state_q == ST_WRITE);
    assign fill_done      = do_write;
    assign fill_done_way  = do_write ? lru_fill_way : '0;
    assign lru_fill_en    = accept_fill;
    assign lru_fill_set   = fill_set;
    assign lru_access_en  = req_valid & req_ready;
    assign lru_access_set = req_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            if (do_write) begin
                valid_q[fill_set_q][lru_fill_way] <= 1'b1;
            end
`ifdef CACHE_TAG_FLUSH_EN
            if (state_q == ST_FLUSH) begin
                valid_q[flush_cnt_q] <= '0;
            end
`endif
        end
    end

    // Tag storage is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_q[fill_set_q][lru_fill_way] <= fill_tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_set_q   <= '0;
            s2_tag_q   <= '0;
            s2_vbits_q <= '0;
        end else begin
            s2_valid_q <= lru_access_en;
            if (lru_access_en) begin
                s2_set_q   <= req_set;
                s2_tag_q   <= req_tag;
                s2_vbits_q <= valid_q[req_set];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lru_access_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                s2_tags_q[w] <= tag_q[req_set][w];
            end
        end
    end

    // Scan from the top way down so the lowest matching way is the one reported.
    always_comb begin
        resp_hit = 1'b0;
        resp_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (s2_valid_q && s2_vbits_q[w] && (s2_tags_q[w] == s2_tag_q)) begin
                resp_hit = 1'b1;
                resp_way = NUM_WAYS_LOG'(w);
            end
        end
    end

    assign resp_valid     = s2_valid_q;
    assign resp_set       = s2_set_q;
    assign resp_tag       = s2_tag_q;
    assign lru_update_en  = resp_valid & resp_hit;
    assign lru_update_way = resp_way;

`ifdef CACHE_TAG_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= (state_q == ST_FLUSH) && (flush_cnt_q == LAST_SET);
            if (state_q == ST_FLUSH) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end else begin
                flush_cnt_q <= '0;
            end
        end
    end

    assign flush_busy = (state_q == ST_FLUSH);
    assign flush_done = flush_done_q;
`endif

endmodule
